// File: rtl/hs_ad_capture.sv
// Triggered capture of an 8-bit high-speed ADC stream into a circular record
// with fixed pre-trigger depth; the frozen record is read back linearised.
module hs_ad_capture #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 1024,
    parameter int ADDR_W   = 10,
    parameter int PRE_TRIG = 128
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ad_clk_o,
    input  logic [DATA_W-1:0] ad_data_i,
    input  logic              arm_i,
    input  logic [DATA_W-1:0] trig_level_i,
    input  logic              force_trig_i,
    output logic              busy_o,
    output logic              done_o,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_TRIG - 1);
    localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(DEPTH - PRE_TRIG - 2);
    localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE_TRIG);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];

    state_t            state_q;
    logic [DATA_W-1:0] cur_q;
    logic [DATA_W-1:0] prev_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] start_ptr_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              busy_q;
    logic              done_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

    logic              wr_en_s;
    logic              trig_s;
    logic              rd_fire_s;
    logic [ADDR_W-1:0] rd_phys_s;

    // The ADC latches on the falling edge of clk so its output is settled at our rising edge.
    assign ad_clk_o   = ~clk;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;

    // Write enable, trigger detection and linearised read address.
    always_comb begin
        wr_en_s   = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
        trig_s    = (state_q == S_WAIT) &&
                    (((prev_q < trig_level_i) && (cur_q >= trig_level_i)) || force_trig_i);
        rd_fire_s = rd_en_i && (state_q == S_DONE);
        rd_phys_s = start_ptr_q + rd_addr_i;
    end

    // Input sample pipeline: cur is what gets stored, prev only feeds the edge detector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_q  <= {DATA_W{1'b0}};
            prev_q <= {DATA_W{1'b0}};
        end else begin
            cur_q  <= ad_data_i;
            prev_q <= cur_q;
        end
    end

    // Capture sequencer with registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= {ADDR_W{1'b0}};
            start_ptr_q <= {ADDR_W{1'b0}};
            cnt_q       <= {ADDR_W{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (arm_i) begin
                        state_q <= S_PRE;
                        cnt_q   <= {ADDR_W{1'b0}};
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                S_PRE: begin
                    wr_ptr_q <= wr_ptr_q + ONE;
                    if (cnt_q == PRE_LAST) begin
                        state_q <= S_WAIT;
                        cnt_q   <= {ADDR_W{1'b0}};
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                S_WAIT: begin
                    wr_ptr_q <= wr_ptr_q + ONE;
                    if (trig_s) begin
                        // The sample written this cycle sits at wr_ptr and becomes record index PRE_TRIG.
                        start_ptr_q <= wr_ptr_q - PRE_OFS;
                        state_q     <= S_POST;
                        cnt_q       <= {ADDR_W{1'b0}};
                    end
                end
                S_POST: begin
                    wr_ptr_q <= wr_ptr_q + ONE;
                    if (cnt_q == POST_LAST) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Record buffer write port.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= cur_q;
        end
    end

    // Registered read port, only serviced while the record is frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q  <= {DATA_W{1'b0}};
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_fire_s;
            if (rd_fire_s) begin
                rd_data_q <= mem_q[rd_phys_s];
            end
        end
    end

endmodule

// File: tb/tb_hs_ad_capture.sv
// Randomised self-checking bench for hs_ad_capture; the reference model derives
// each record from the logged sample stream and the trigger rule.
module tb_hs_ad_capture;

    localparam int DATA_W   = 8;
    localparam int DEPTH    = 1024;
    localparam int ADDR_W   = 10;
    localparam int PRE_TRIG = 128;

    logic              clk = 1'b0;
    logic              rst;
    logic              ad_clk;
    logic [DATA_W-1:0] ad_data;
    logic              arm;
    logic [DATA_W-1:0] trig_level;
    logic              force_trig;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    hs_ad_capture #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .PRE_TRIG(PRE_TRIG)
    ) dut (
        .clk(clk), .rst(rst), .ad_clk_o(ad_clk), .ad_data_i(ad_data),
        .arm_i(arm), .trig_level_i(trig_level), .force_trig_i(force_trig),
        .busy_o(busy), .done_o(done), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data), .rd_valid_o(rd_valid)
    );

    always #4 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int mode   = 0;
    logic [7:0] ramp_ofs = 8'd0;

    logic [7:0] samp [65536];
    bit         frc  [65536];
    logic [7:0] exp_rec [DEPTH];
    logic [7:0] got_d [DEPTH];
    logic       got_v [DEPTH];

    // Log what the DUT sees at every rising edge; cyc is the index of the next edge.
    always @(posedge clk) begin
        samp[cyc] <= ad_data;
        frc[cyc]  <= force_trig;
        cyc       <= cyc + 1;
    end

    // ADC data source: ramp (cycle counter), constant, or random.
    always @(negedge clk) begin
        case (mode)
            0:       ad_data = 8'(cyc) + ramp_ofs;
            1:       ad_data = 8'd50;
            default: ad_data = 8'($urandom);
        endcase
    end

    // Reference: writes start one edge after arm, write j stores the sample taken at edge a+j.
    // The trigger is the first write j >= PRE_TRIG with a rising crossing or a force;
    // the record is the DEPTH consecutive written samples with the trigger at index PRE_TRIG.
    task automatic model_capture(input int a, input logic [7:0] lvl, output int done_edge);
        bit found = 1'b0;
        done_edge = -2;
        for (int j = PRE_TRIG; (a + 1 + j < cyc) && !found; j++) begin
            if (((samp[a+j-1] < lvl) && (samp[a+j] >= lvl)) || frc[a+1+j]) begin
                found     = 1'b1;
                done_edge = a + j + DEPTH - PRE_TRIG;
                for (int i = 0; i < DEPTH; i++) exp_rec[i] = samp[a+j-PRE_TRIG+i];
            end
        end
    endtask

    task automatic do_arm(output int a);
        @(negedge clk);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        a = cyc - 1;
    endtask

    task automatic goto_edge(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic wait_done(input int budget, output int edge_seen);
        edge_seen = -1;
        for (int k = 0; (k < budget) && (edge_seen < 0); k++) begin
            @(negedge clk);
            if (done === 1'b1) edge_seen = cyc - 1;
        end
    endtask

    task automatic read_all();
        for (int i = 0; i <= DEPTH; i++) begin
            @(negedge clk);
            if (i > 0) begin
                got_d[i-1] = rd_data;
                got_v[i-1] = rd_valid;
            end
            if (i < DEPTH) begin
                rd_en   = 1'b1;
                rd_addr = ADDR_W'(i);
            end else begin
                rd_en = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, rd_valid, rd_data} !== 11'd0) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b vld=%b data=%0d want all 0", busy, done, rd_valid, rd_data);
        end
        checks++;
        if (ad_clk !== 1'b1) begin
            errors++;
            $display("FAIL ad_clk_low_phase got %b want 1", ad_clk);
        end
        @(posedge clk); #1;
        checks++;
        if (ad_clk !== 1'b0) begin
            errors++;
            $display("FAIL ad_clk_high_phase got %b want 0", ad_clk);
        end
        @(negedge clk);
        rst = 1'b0;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        checks++;
        if ({busy, done, rd_valid} !== 3'b000) begin
            errors++;
            $display("FAIL idle_after_reset got busy=%b done=%b vld=%b want 0 0 0", busy, done, rd_valid);
        end
    endtask

    task automatic test_ramp();
        int a, e, ee;
        mode = 0; ramp_ofs = 8'($urandom); trig_level = 8'd100;
        do_arm(a);
        wait_done(4000, e);
        model_capture(a, trig_level, ee);
        checks++;
        if (e !== ee) begin errors++; $display("FAIL ramp_done_edge got %0d want %0d", e, ee); end
        read_all();
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (got_v[i] !== 1'b1 || got_d[i] !== exp_rec[i]) begin
                errors++;
                $display("FAIL ramp_rec[%0d] got v=%b d=%0d want v=1 d=%0d", i, got_v[i], got_d[i], exp_rec[i]);
            end
        end
        checks++;
        if (got_d[PRE_TRIG] !== 8'd100 || got_d[0] !== 8'd228) begin
            errors++;
            $display("FAIL ramp_anchor got rec0=%0d rec128=%0d want 228 100", got_d[0], got_d[PRE_TRIG]);
        end
    endtask

    task automatic test_random();
        int a, e, ee;
        mode = 2; trig_level = 8'($urandom_range(64, 192));
        do_arm(a);
        wait_done(6000, e);
        model_capture(a, trig_level, ee);
        checks++;
        if (e !== ee) begin errors++; $display("FAIL rand_done_edge got %0d want %0d", e, ee); end
        read_all();
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (got_v[i] !== 1'b1 || got_d[i] !== exp_rec[i]) begin
                errors++;
                $display("FAIL rand_rec[%0d] got v=%b d=%0d want v=1 d=%0d", i, got_v[i], got_d[i], exp_rec[i]);
            end
        end
    endtask

    task automatic test_no_cross();
        int a, e, ee, fe, stuck;
        mode = 1; trig_level = 8'd100; stuck = 0;
        do_arm(a);
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (busy !== 1'b1 || done !== 1'b0) stuck++;
        end
        checks++;
        if (stuck != 0) begin errors++; $display("FAIL nocross_wait got %0d bad cycles want 0", stuck); end
        @(negedge clk); force_trig = 1'b1;
        @(negedge clk); force_trig = 1'b0;
        fe = cyc - 1;
        wait_done(2000, e);
        model_capture(a, trig_level, ee);
        checks++;
        if (e !== fe + 895) begin errors++; $display("FAIL nocross_done_edge got %0d want %0d", e, fe + 895); end
        checks++;
        if (e !== ee) begin errors++; $display("FAIL nocross_model_edge got %0d want %0d", e, ee); end
        read_all();
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (got_v[i] !== 1'b1 || got_d[i] !== 8'd50) begin
                errors++;
                $display("FAIL nocross_rec[%0d] got v=%b d=%0d want v=1 d=50", i, got_v[i], got_d[i]);
            end
        end
    endtask

    task automatic test_rearm();
        int a, e, ee;
        mode = 0; ramp_ofs = 8'($urandom); trig_level = 8'd100;
        do_arm(a);
        goto_edge(a + 150); arm = 1'b1; @(negedge clk); arm = 1'b0;
        goto_edge(a + 900); arm = 1'b1; @(negedge clk); arm = 1'b0;
        wait_done(4000, e);
        model_capture(a, trig_level, ee);
        checks++;
        if (e !== ee) begin errors++; $display("FAIL rearm_done_edge got %0d want %0d", e, ee); end
        read_all();
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (got_v[i] !== 1'b1 || got_d[i] !== exp_rec[i]) begin
                errors++;
                $display("FAIL rearm_rec[%0d] got v=%b d=%0d want v=1 d=%0d", i, got_v[i], got_d[i], exp_rec[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        int a, e, ee;
        mode = 0; ramp_ofs = 8'($urandom); trig_level = 8'd100;
        do_arm(a);
        goto_edge(a + 700);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %b want 1", busy); end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, rd_valid} !== 3'b000) begin
            errors++;
            $display("FAIL midrst_async got busy=%b done=%b vld=%b want 0 0 0", busy, done, rd_valid);
        end
        @(negedge clk); rst = 1'b0;
        do_arm(a);
        wait_done(4000, e);
        model_capture(a, trig_level, ee);
        checks++;
        if (e !== ee) begin errors++; $display("FAIL midrst_done_edge got %0d want %0d", e, ee); end
        read_all();
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (got_v[i] !== 1'b1 || got_d[i] !== exp_rec[i]) begin
                errors++;
                $display("FAIL midrst_rec[%0d] got v=%b d=%0d want v=1 d=%0d", i, got_v[i], got_d[i], exp_rec[i]);
            end
        end
    endtask

    task automatic test_wrap();
        int a, e, ee;
        logic [7:0] tv;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        mode = 0; ramp_ofs = 8'($urandom); trig_level = 8'd0;
        do_arm(a);
        // After reset the first write lands at address 0, so write 1000 is physical address 1000.
        goto_edge(a + 1 + 1000); force_trig = 1'b1;
        @(negedge clk); force_trig = 1'b0;
        wait_done(3000, e);
        model_capture(a, trig_level, ee);
        checks++;
        if (e !== ee) begin errors++; $display("FAIL wrap_done_edge got %0d want %0d", e, ee); end
        read_all();
        tv = 8'(a + 1000) + ramp_ofs;
        checks++;
        if (got_d[PRE_TRIG] !== tv) begin
            errors++;
            $display("FAIL wrap_trig_sample got %0d want %0d", got_d[PRE_TRIG], tv);
        end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (got_v[i] !== 1'b1 || got_d[i] !== exp_rec[i]) begin
                errors++;
                $display("FAIL wrap_rec[%0d] got v=%b d=%0d want v=1 d=%0d", i, got_v[i], got_d[i], exp_rec[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int a, e, ee, r, r_prev;
        mode = 2; trig_level = 8'($urandom_range(64, 192));
        do_arm(a);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k > 0) begin
                checks++;
                if (rd_valid !== 1'b0) begin errors++; $display("FAIL gate_busy_read got vld=%b want 0", rd_valid); end
            end
            rd_en = 1'b1; rd_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
        end
        @(negedge clk); rd_en = 1'b0;
        wait_done(6000, e);
        model_capture(a, trig_level, ee);
        checks++;
        if (e !== ee) begin errors++; $display("FAIL b2b_done_edge got %0d want %0d", e, ee); end
        r_prev = 0;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            if (k > 0) begin
                checks++;
                if (rd_valid !== 1'b1 || rd_data !== exp_rec[r_prev]) begin
                    errors++;
                    $display("FAIL b2b_read[%0d] got v=%b d=%0d want v=1 d=%0d", r_prev, rd_valid, rd_data, exp_rec[r_prev]);
                end
            end
            if (k < 4) begin
                r = $urandom_range(0, DEPTH - 1);
                rd_en = 1'b1; rd_addr = ADDR_W'(r); r_prev = r;
            end else begin
                rd_en = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle_valid got %b want 0", rd_valid); end
        r = $urandom_range(0, DEPTH - 1);
        arm = 1'b1; rd_en = 1'b1; rd_addr = ADDR_W'(r);
        @(negedge clk);
        arm = 1'b0; rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp_rec[r]) begin
            errors++;
            $display("FAIL arm_and_read[%0d] got v=%b d=%0d want v=1 d=%0d", r, rd_valid, rd_data, exp_rec[r]);
        end
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL arm_and_read_restart got busy=%b done=%b want 1 0", busy, done);
        end
    endtask

    initial begin
        arm = 1'b0; force_trig = 1'b0; rd_en = 1'b0; rd_addr = '0; trig_level = 8'd100;
        test_reset();
        test_ramp();
        test_random();
        test_no_cross();
        test_rearm();
        test_mid_reset();
        test_wrap();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
